// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencer: lamp codes, phase
// encoding and default phase durations.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        CW_GREEN  = 3'd3,
        CW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5
    } state_t;

    localparam int DEF_MIN_GREEN_HW = 8;
    localparam int DEF_GREEN_CW     = 5;
    localparam int DEF_YELLOW_T     = 2;
    localparam int DEF_ALL_RED_T    = 1;
    localparam int DEF_CNT_W        = 4;

    function automatic logic [1:0] hw_lamp(input state_t s);
        logic [1:0] l;
        case (s)
            HW_GREEN:  l = LAMP_GREEN;
            HW_YELLOW: l = LAMP_YELLOW;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] cw_lamp(input state_t s);
        logic [1:0] l;
        case (s)
            CW_GREEN:  l = LAMP_GREEN;
            CW_YELLOW: l = LAMP_YELLOW;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/debug outputs of the phase scheduler.
interface traffic_phase_scheduler_if;
    logic       x;
    logic       ped_req;
    logic       emg_req;
    logic [1:0] hw;
    logic [1:0] cw;
    logic       walk;
    logic [2:0] phase;

    modport master (output x, ped_req, emg_req, input hw, cw, walk, phase);
    modport slave  (input x, ped_req, emg_req, output hw, cw, walk, phase);
endinterface

// File: rtl/phase_timer.sv
// Per-phase cycle timer: synchronous clear, counts up to dur_m1 and holds there.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur_m1,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Counter: restart on phase entry, saturate at the programmed end value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (count_r != dur_m1) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == dur_m1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer with emergency preemption.
// Build option PED_WALK_EN adds the pedestrian request latch and walk lamp.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN_HW = DEF_MIN_GREEN_HW,
    parameter int GREEN_CW     = DEF_GREEN_CW,
    parameter int YELLOW_T     = DEF_YELLOW_T,
    parameter int ALL_RED_T    = DEF_ALL_RED_T,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    traffic_phase_scheduler_if.slave   bus
);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] dur_m1_s;
    logic             done_s;
    logic             clr_s;
    logic             request_s;
    logic [1:0]       hw_s;
    logic [1:0]       cw_s;
    logic [1:0]       hw_r;
    logic [1:0]       cw_r;
    logic [2:0]       phase_r;
    logic             walk_out_s;

    // Duration of the phase currently being timed, as its final timer value.
    always_comb begin
        dur_m1_s = CNT_W'(0);
        case (state_r)
            HW_GREEN:             dur_m1_s = CNT_W'(MIN_GREEN_HW - 1);
            HW_YELLOW, CW_YELLOW: dur_m1_s = CNT_W'(YELLOW_T - 1);
            ALL_RED1, ALL_RED2:   dur_m1_s = CNT_W'(ALL_RED_T - 1);
            CW_GREEN:             dur_m1_s = CNT_W'(GREEN_CW - 1);
            default:              dur_m1_s = CNT_W'(0);
        endcase
    end

    assign clr_s = (state_s != state_r);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_s),
        .dur_m1 (dur_m1_s),
        .done   (done_s)
    );

`ifdef PED_WALK_EN
    logic entry_s;
    logic cw_first_r;
    logic ped_pending_r;
    logic walk_r;

    assign entry_s   = (state_s == CW_GREEN) && (state_r != CW_GREEN);
    assign request_s = bus.x | ped_pending_r;

    // Pedestrian latch; a press in the entry edge or first country-green cycle is absorbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cw_first_r    <= 1'b0;
            ped_pending_r <= 1'b0;
        end else begin
            cw_first_r <= entry_s;
            if (entry_s || cw_first_r) begin
                ped_pending_r <= 1'b0;
            end else if (bus.ped_req) begin
                ped_pending_r <= 1'b1;
            end else begin
                ped_pending_r <= ped_pending_r;
            end
        end
    end

    // Walk lamp: captured on country-green entry, dropped when the phase ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            walk_r <= 1'b0;
        end else if (entry_s) begin
            walk_r <= ped_pending_r;
        end else if (state_s != CW_GREEN) begin
            walk_r <= 1'b0;
        end else begin
            walk_r <= walk_r;
        end
    end

    assign walk_out_s = walk_r;
`else
    assign request_s  = bus.x;
    assign walk_out_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= HW_GREEN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clearance states ignore the emergency input.
    always_comb begin
        state_s = state_r;
        case (state_r)
            HW_GREEN: begin
                if (done_s && request_s && !bus.emg_req) begin
                    state_s = HW_YELLOW;
                end else begin
                    state_s = HW_GREEN;
                end
            end
            HW_YELLOW: begin
                if (done_s) state_s = ALL_RED1;
                else        state_s = HW_YELLOW;
            end
            ALL_RED1: begin
                if (done_s) state_s = CW_GREEN;
                else        state_s = ALL_RED1;
            end
            CW_GREEN: begin
                if (done_s || bus.emg_req) state_s = CW_YELLOW;
                else                       state_s = CW_GREEN;
            end
            CW_YELLOW: begin
                if (done_s) state_s = ALL_RED2;
                else        state_s = CW_YELLOW;
            end
            ALL_RED2: begin
                if (done_s) state_s = HW_GREEN;
                else        state_s = ALL_RED2;
            end
            default: state_s = HW_GREEN;
        endcase
    end

    // Lamp decode of the upcoming state so lamps change on the same edge as the state.
    always_comb begin
        hw_s = hw_lamp(state_s);
        cw_s = cw_lamp(state_s);
    end

    // Registered lamp and debug outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_r    <= LAMP_GREEN;
            cw_r    <= LAMP_RED;
            phase_r <= 3'd0;
        end else begin
            hw_r    <= hw_s;
            cw_r    <= cw_s;
            phase_r <= state_s;
        end
    end

    assign bus.hw    = hw_r;
    assign bus.cw    = cw_r;
    assign bus.phase = phase_r;
    assign bus.walk  = walk_out_s;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: cycle model of the phase rules plus hand-derived lamp timelines.
module tb_traffic_phase_scheduler;

`ifdef PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    localparam int T_IDLE = 0;
    localparam int T_VEH  = 1;
    localparam int T_PED  = 2;
    localparam int T_EMG  = 3;
    localparam int T_RST  = 4;

    logic clk;
    logic reset;
    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .MIN_GREEN_HW (8),
        .GREEN_CW     (5),
        .YELLOW_T     (2),
        .ALL_RED_T    (1),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Phase order: HW_GREEN, HW_YELLOW, ALL_RED1, CW_GREEN, CW_YELLOW, ALL_RED2
    int dur[6]    = '{8, 2, 1, 5, 2, 1};
    int hw_tab[6] = '{2, 1, 0, 0, 0, 0};
    int cw_tab[6] = '{0, 0, 0, 2, 1, 0};

    int mp = 0;
    int me = 0;
    bit mpend = 1'b0;
    bit mwalk = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase index and elapsed cycles, stepped on each edge.
    always @(posedge clk) begin
        int d;
        bit go;
        bit pend_old;
        if (reset) begin
            mp = 0; me = 0; mpend = 1'b0; mwalk = 1'b0;
        end else begin
            d = dur[mp];
            pend_old = mpend;
            case (mp)
                0:       go = (me == d - 1) && (bus.x || (PED_EN && mpend)) && !bus.emg_req;
                3:       go = (me == d - 1) || bus.emg_req;
                default: go = (me == d - 1);
            endcase
            if (PED_EN) begin
                if ((mp == 2 && go) || (mp == 3 && me == 0)) mpend = 1'b0;
                else if (bus.ped_req)                       mpend = 1'b1;
            end
            if (go) begin
                mp = (mp + 1) % 6;
                me = 0;
                mwalk = (mp == 3) && pend_old;
            end else if (me < d - 1) begin
                me++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hw",    int'(bus.hw),    hw_tab[mp]);
            chk("cw",    int'(bus.cw),    cw_tab[mp]);
            chk("walk",  int'(bus.walk),  int'(mwalk));
            chk("phase", int'(bus.phase), mp);
        end
    end

    // Hand-derived lamp timelines for each directed scenario.
    task automatic lit_check(input int t, input int c);
        int m, vhw, vcw, ehw, ecw, ew;
        m   = c % 19;
        vhw = (m < 8) ? 2 : (m < 10) ? 1 : 0;
        vcw = (m >= 11 && m <= 15) ? 2 : (m == 16 || m == 17) ? 1 : 0;
        ehw = 2; ecw = 0; ew = 0;
        case (t)
            T_VEH: begin ehw = vhw; ecw = vcw; end
            T_PED: begin
                if (PED_EN && c < 19) begin ehw = vhw; ecw = vcw; end
                ew = (PED_EN && c >= 11 && c <= 15) ? 1 : 0;
            end
            T_EMG: begin
                if (c < 13)       begin ehw = vhw; ecw = vcw; end
                else if (c <= 14) begin ehw = 0;   ecw = 1;   end
                else if (c == 15) begin ehw = 0;   ecw = 0;   end
            end
            T_RST: begin
                if (c < 14) begin ehw = vhw; ecw = vcw; end
                if (c == 14) chk("rst_phase", int'(bus.phase), 0);
            end
            default: begin ehw = 2; ecw = 0; end
        endcase
        chk("lit_hw",   int'(bus.hw),   ehw);
        chk("lit_cw",   int'(bus.cw),   ecw);
        chk("lit_walk", int'(bus.walk), ew);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.x = 1'b0; bus.ped_req = 1'b0; bus.emg_req = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_test(input int t, input int len);
        do_reset();
        for (int c = 0; c < len; c++) begin
            bus.x       = (t == T_VEH || t == T_EMG || (t == T_RST && c < 13));
            bus.ped_req = ((t == T_PED && (c == 3 || c == 11)) || (t == T_RST && c == 12));
            bus.emg_req = (t == T_EMG && c >= 12);
            reset       = (t == T_RST && c == 13);
            @(negedge clk);
            lit_check(t, c);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.x = 1'b0; bus.ped_req = 1'b0; bus.emg_req = 1'b0;
        run_test(T_IDLE, 30);
        run_test(T_VEH,  30);
        run_test(T_PED,  40);
        run_test(T_EMG,  30);
        run_test(T_RST,  45);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed phase sequencer for a two-road intersection: highway (hw) and country road (cw). It holds the highway green by default. It grants the country road a green phase on a vehicle-sensor or pedestrian request, and it supports emergency preemption that returns priority to the highway. The block drives the lamp codes for both roads directly and replaces the ad-hoc signal controller as the intersection's top-level sequencer.

## Interface
Parameters:
- MIN_GREEN_HW, 8: minimum highway-green cycles before a country request is honoured.
- GREEN_CW, 5: country-green cycles.
- YELLOW_T, 2: yellow cycles, both roads.
- ALL_RED_T, 1: all-red clearance cycles between phases.
- CNT_W, 4: timer width; must hold max(duration) − 1. Every duration is ≥ 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- x  in  1  country-road vehicle sensor, level-sensitive.
- ped_req  in  1  pedestrian button, pulse; the block latches it.
- emg_req  in  1  emergency preempt, level; forces highway priority.
- hw  out  2  highway lamp: 0 = RED, 1 = YELLOW, 2 = GREEN (3 is never driven).
- cw  out  2  country lamp, same encoding.
- walk  out  1  pedestrian walk indication.
- phase  out  3  current state code, for debug.

## Operation
- Moore FSM. States: HW_GREEN, HW_YELLOW, ALL_RED1, CW_GREEN, CW_YELLOW, ALL_RED2.
- The phase timer clears to 0 on every state entry and increments each cycle while in the state. "done(D)" means timer == D − 1.
- Transitions:
  - HW_GREEN → HW_YELLOW when done(MIN_GREEN_HW) and (x or ped_pending) and !emg_req. Otherwise HW_GREEN holds, with the timer saturating at MIN_GREEN_HW − 1.
  - HW_YELLOW → ALL_RED1 on done(YELLOW_T).
  - ALL_RED1 → CW_GREEN on done(ALL_RED_T).
  - CW_GREEN → CW_YELLOW on done(GREEN_CW), or on the first cycle emg_req = 1.
  - CW_YELLOW → ALL_RED2 on done(YELLOW_T).
  - ALL_RED2 → HW_GREEN on done(ALL_RED_T).
- emg_req has no effect in yellow or all-red states; the clearance sequence always completes.
- Lamp decode:
  - HW_GREEN: hw = GREEN, cw = RED.
  - HW_YELLOW: hw = YELLOW, cw = RED.
  - ALL_RED1, ALL_RED2: both RED.
  - CW_GREEN: hw = RED, cw = GREEN.
  - CW_YELLOW: hw = RED, cw = YELLOW.
- The two roads are never non-RED simultaneously.
- ped_pending is set by ped_req and cleared on entry to CW_GREEN. If ped_req arrives in the entry cycle, it counts as served and the clear wins.
- walk = 1 throughout a CW_GREEN phase whose entry consumed ped_pending; walk = 0 otherwise.

## Timing
- Inputs are sampled at the rising edge of clk. All outputs are registered, and state, lamps, and walk update on the same edge.
- Request-to-response latency is one cycle. A request sampled at the edge ending cycle n changes the outputs in cycle n + 1.
- Reset values (reset sampled high):
  - state = HW_GREEN, timer = 0, ped_pending = 0.
  - hw = 2, cw = 0, walk = 0, phase = 0.
- Reset mid-operation takes effect on the next edge from any state, with no clearance sequence.
- Full country cycle with defaults: 2 + 1 + 5 + 2 + 1 = 11 cycles from HW_GREEN exit back to HW_GREEN.

## Configuration
- PED_WALK_EN defined: ped_pending latch and walk output logic are present, as described above.
- PED_WALK_EN undefined:
  - ped_req is ignored (port kept), walk is tied to 0, and no latch is built.
  - Only x triggers a country phase.

## Structure
- Shared package traffic_pkg holds:
  - lamp encoding constants LAMP_RED / LAMP_YELLOW / LAMP_GREEN;
  - state encoding for the six states;
  - default duration constants.
- Sub-module phase_timer: CNT_W counter with synchronous clear, saturating hold, and a compare-to-(D − 1) done output. The FSM instantiates one.

## Test plan
- Idle: reset for 2 cycles, then x = 0 and ped_req = 0 for 30 cycles → hw = 2, cw = 0, walk = 0 every cycle.
- Vehicle: x = 1 from the first post-reset cycle 0 → hw = GREEN cycles 0–7, YELLOW 8–9, all-red 10, cw = GREEN 11–15, cw YELLOW 16–17, all-red 18, hw GREEN 19. The sequence repeats while x stays 1.
- Pedestrian (PED_WALK_EN): x = 0, one-cycle ped_req at cycle 3 → same timing as the vehicle case, walk = 1 in cycles 11–15 only. A second ped_req pulse at cycle 11 causes no new phase.
- Preempt: x = 1, emg_req = 1 from cycle 12 onward:
  - cw YELLOW cycles 13–14, all-red 15, hw GREEN from 16;
  - HW_GREEN is held while emg_req = 1 even with x = 1.
- Reset mid-phase: assert reset during cycle 13 (CW_GREEN) → cycle 14 shows hw = 2, cw = 0, walk = 0, phase = 0, and the pending request is cleared.
- Macro off: PED_WALK_EN undefined, x = 0, ped_req pulse → no phase change for 30 cycles, walk = 0.
